// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if
// Bundles the loader's byte stream, fetch request, memory write/read port and
// status signals. Clock and reset are kept as plain ports on the loader.
//
// Modports:
//   slave  - the loader: consumes i_* (debug unit + pipeline), drives o_*.
//   master - the environment (debug unit, pipeline, memory): drives i_*, sees o_*.
interface instr_mem_loader_if #(
    parameter int MEMORY_WIDTH = 8,
    parameter int MEMORY_DEPTH = 64,
    parameter int NB_ADDR      = 32
) ();
    localparam int NB_COUNT = $clog2(MEMORY_DEPTH) + 1;

    logic                    i_load_start;
    logic                    i_rx_valid;
    logic [MEMORY_WIDTH-1:0] i_rx_data;
    logic                    i_fetch_enable;
    logic [NB_ADDR-1:0]      i_pc;

    logic                    o_mem_write_enable;
    logic [NB_ADDR-1:0]      o_mem_write_addr;
    logic [MEMORY_WIDTH-1:0] o_mem_write_data;
    logic                    o_mem_read_enable;
    logic [NB_ADDR-1:0]      o_mem_read_addr;
    logic                    o_fetch_stall;
    logic                    o_program_loaded;
    logic                    o_load_full;
    logic [NB_COUNT-1:0]     o_byte_count;

    modport slave (
        input  i_load_start, i_rx_valid, i_rx_data, i_fetch_enable, i_pc,
        output o_mem_write_enable, o_mem_write_addr, o_mem_write_data,
               o_mem_read_enable, o_mem_read_addr, o_fetch_stall,
               o_program_loaded, o_load_full, o_byte_count
    );

    modport master (
        output i_load_start, i_rx_valid, i_rx_data, i_fetch_enable, i_pc,
        input  o_mem_write_enable, o_mem_write_addr, o_mem_write_data,
               o_mem_read_enable, o_mem_read_addr, o_fetch_stall,
               o_program_loaded, o_load_full, o_byte_count
    );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Owns the write side of the instruction memory and gates its read side.
// Bytes from the debug unit are written to consecutive byte addresses; the
// session ends on a word-aligned HALT_WORD or when memory is full. Fetch is
// blocked until a session has completed with HALT.
//
// Ports:
//   i_clock  - system clock, rising edge
//   i_reset  - asynchronous, active-high reset
//   bus      - instr_mem_loader_if.slave (byte stream in, fetch request in,
//              memory write/read port out, stall and status out)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no session; fetch passes through once a program is loaded
// LOAD  | writing received bytes, checking aligned words for HALT
// DONE  | session just ended; one cycle before returning to IDLE
module instr_mem_loader #(
    parameter int                    MEMORY_WIDTH   = 8,
    parameter int                    MEMORY_DEPTH   = 64,
    parameter int                    NB_ADDR        = 32,
    parameter int                    NB_INSTRUCTION = 32,
    parameter logic [NB_INSTRUCTION-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic          i_clock,
    input  logic          i_reset,
    instr_mem_loader_if.slave bus
);
    localparam int NB_COUNT = $clog2(MEMORY_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [NB_COUNT-1:0]       byte_count;
    logic [NB_INSTRUCTION-1:0] word;
    logic                      wr_en;
    logic [NB_ADDR-1:0]        wr_addr;
    logic [MEMORY_WIDTH-1:0]   wr_data;
    logic                      program_loaded;
    logic                      load_full;

    logic [NB_COUNT-1:0]       next_count;
    logic [NB_INSTRUCTION-1:0] next_word;

    always_comb begin
        next_count = byte_count + 1'b1;
        next_word  = {word[NB_INSTRUCTION-MEMORY_WIDTH-1:0], bus.i_rx_data};
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state          <= IDLE;
            byte_count     <= '0;
            word           <= '0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            program_loaded <= 1'b0;
            load_full      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    // A byte coincident with the start pulse is dropped on purpose.
                    if (bus.i_load_start) begin
                        state          <= LOAD;
                        byte_count     <= '0;
                        word           <= '0;
                        program_loaded <= 1'b0;
                        load_full      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.i_rx_valid) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= NB_ADDR'(byte_count);
                        wr_data    <= bus.i_rx_data;
                        byte_count <= next_count;
                        word       <= next_word;
                        // HALT only counts on word boundaries; it wins over
                        // "full" when both happen on the last byte.
                        if (next_count[1:0] == 2'b00 && next_word == HALT_WORD) begin
                            state          <= DONE;
                            program_loaded <= 1'b1;
                        end else if (next_count == NB_COUNT'(MEMORY_DEPTH)) begin
                            state     <= DONE;
                            load_full <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_mem_write_enable = wr_en;
    assign bus.o_mem_write_addr   = wr_addr;
    assign bus.o_mem_write_data   = wr_data;
    assign bus.o_program_loaded   = program_loaded;
    assign bus.o_load_full        = load_full;
    assign bus.o_byte_count       = byte_count;

    assign bus.o_mem_read_enable  = bus.i_fetch_enable & program_loaded & (state == IDLE);
    assign bus.o_mem_read_addr    = bus.i_pc;
    assign bus.o_fetch_stall      = (state != IDLE) | ~program_loaded;
endmodule
